// File: rtl/cpu_core_p_if.sv
// rtl/cpu_core_p_if.sv - instruction and data memory bus between cpu_core_p and its memories
// Both ports are plain request/ack: the master holds req and its qualifiers until ack.
interface cpu_core_p_if #(
  parameter int AW = 8,
  parameter int DW = 16
);
  logic [AW-1:0] im_addr;
  logic          im_req;
  logic [15:0]   im_data;
  logic          im_ack;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          dm_we;
  logic          dm_req;
  logic [DW-1:0] dm_rdata;
  logic          dm_ack;

  modport master (
    output im_addr, im_req, dm_addr, dm_wdata, dm_we, dm_req,
    input  im_data, im_ack, dm_rdata, dm_ack
  );

  modport slave (
    input  im_addr, im_req, dm_addr, dm_wdata, dm_we, dm_req,
    output im_data, im_ack, dm_rdata, dm_ack
  );
endinterface

// File: rtl/cpu_core_p.sv
// rtl/cpu_core_p.sv - multi-cycle 16-bit-instruction core: fetch, decode, execute, memory
// One instruction at a time; memory ports are request/ack with arbitrary wait states.
module cpu_core_p #(
  parameter int DW   = 16,
  parameter int AW   = 8,
  parameter int NREG = 4
) (
  input  logic          clk,
  input  logic          reset,
  cpu_core_p_if.master  bus,
  output logic [AW-1:0] o_pc,
  output logic [15:0]   o_ir,
  output logic [2:0]    o_state,
  output logic          o_zf,
  output logic          o_cf,
  input  logic [2:0]    o_reg_sel,
  output logic [DW-1:0] o_reg_data
);

  localparam int RW = $clog2(NREG);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  state_t        state_q;
  logic [AW-1:0] pc_q;
  logic [15:0]   ir_q;
  logic [DW-1:0] regs_q [NREG];
  logic          zf_q, cf_q;
  logic [AW-1:0] dm_addr_q;
  logic [DW-1:0] dm_wdata_q;
  logic          dm_we_q;

  // Instruction fields; register indices wrap modulo NREG by taking the low bits.
  logic [3:0]    op;
  logic [RW-1:0] rd, rs;
  logic [AW-1:0] imm_aw;
  logic [DW-1:0] imm_dw;
  logic [DW-1:0] ra, rb;

  assign op     = ir_q[15:12];
  assign rd     = ir_q[9 +: RW];
  assign rs     = ir_q[0 +: RW];
  assign imm_aw = AW'(ir_q[7:0]);
  assign imm_dw = DW'(ir_q[7:0]);
  assign ra     = regs_q[rd];
  assign rb     = regs_q[rs];

  // Execute-stage datapath: result, carry and the writeback/flag/jump enables.
  logic [DW-1:0] res_d;
  logic          c_d, z_d, wr_d, flag_d, jump_d;

  // ALU and branch decision from the current instruction and pre-write register values.
  always_comb begin
    res_d  = '0;
    c_d    = 1'b0;
    wr_d   = 1'b0;
    flag_d = 1'b0;
    jump_d = 1'b0;
    case (op)
      4'h1: begin res_d = imm_dw; wr_d = 1'b1; end
      4'h4: begin res_d = rb;     wr_d = 1'b1; end
      4'h5: begin {c_d, res_d} = {1'b0, ra} + {1'b0, rb}; wr_d = 1'b1; flag_d = 1'b1; end
      // The extra top bit of the widened difference is the borrow, set exactly when ra < rb.
      4'h6: begin {c_d, res_d} = {1'b0, ra} - {1'b0, rb}; wr_d = 1'b1; flag_d = 1'b1; end
      4'h7: begin res_d = ra & rb; wr_d = 1'b1; flag_d = 1'b1; end
      4'h8: begin res_d = ra | rb; wr_d = 1'b1; flag_d = 1'b1; end
      4'h9: begin res_d = ra ^ rb; wr_d = 1'b1; flag_d = 1'b1; end
      4'hA: begin res_d = {ra[DW-2:0], 1'b0}; c_d = ra[DW-1]; wr_d = 1'b1; flag_d = 1'b1; end
      4'hB: begin res_d = {1'b0, ra[DW-1:1]}; c_d = ra[0];    wr_d = 1'b1; flag_d = 1'b1; end
      4'hC: jump_d = zf_q;
      4'hD: jump_d = cf_q;
      4'hE: jump_d = 1'b1;
      default: ;
    endcase
    z_d = (res_d == '0);
  end

  // Main control FSM with all architectural state; reset overrides any ack in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_FETCH;
      pc_q       <= '0;
      ir_q       <= '0;
      zf_q       <= 1'b0;
      cf_q       <= 1'b0;
      dm_addr_q  <= '0;
      dm_wdata_q <= '0;
      dm_we_q    <= 1'b0;
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (bus.im_ack) begin
            ir_q    <= bus.im_data;
            pc_q    <= pc_q + AW'(1);
            state_q <= S_DECODE;
          end
        end
        S_DECODE: state_q <= S_EXEC;
        S_EXEC: begin
          if (wr_d) regs_q[rd] <= res_d;
          if (flag_d) begin
            zf_q <= z_d;
            cf_q <= c_d;
          end
          if (jump_d) pc_q <= imm_aw;
          case (op)
            4'h2, 4'h3: begin
              dm_addr_q  <= imm_aw;
              dm_wdata_q <= ra;
              dm_we_q    <= (op == 4'h3);
              state_q    <= S_MEM;
            end
            4'hF:    state_q <= S_HALT;
            default: state_q <= S_FETCH;
          endcase
        end
        S_MEM: begin
          if (bus.dm_ack) begin
            if (!dm_we_q) regs_q[rd] <= bus.dm_rdata;
            dm_we_q <= 1'b0;
            state_q <= S_FETCH;
          end
        end
        S_HALT:  state_q <= S_HALT;
        default: state_q <= S_FETCH;
      endcase
    end
  end

  // Requests are decoded from the state register and masked by reset, so nothing is
  // issued while reset is held and the fetch of address 0 starts as soon as it drops.
  assign bus.im_addr  = pc_q;
  assign bus.im_req   = (state_q == S_FETCH) && !reset;
  assign bus.dm_req   = (state_q == S_MEM) && !reset;
  assign bus.dm_addr  = dm_addr_q;
  assign bus.dm_wdata = dm_wdata_q;
  assign bus.dm_we    = dm_we_q && !reset;

  assign o_pc    = pc_q;
  assign o_ir    = ir_q;
  assign o_state = state_q;
  assign o_zf    = zf_q;
  assign o_cf    = cf_q;

  // Observer register read; the select is reduced modulo NREG.
  always_comb begin
    o_reg_data = '0;
    for (int i = 0; i < NREG; i++) begin
      if ((int'(o_reg_sel) % NREG) == i) o_reg_data = regs_q[i];
    end
  end

endmodule
